// File: rtl/chunked_addsub_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package chunked_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

  // Number of chunks an operation is split into.
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Width of the chunk index register; at least one bit even for a single chunk.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Two's complement saturation pattern: max positive, or max negative when neg is set.
  // Valid for widths up to 64; callers keep the low width bits.
  function automatic logic [63:0] sat_pattern(input int unsigned width, input logic neg);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/chunked_addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry-in, carry-out and carry into its MSB.
module addsub_chunk #(
  parameter int unsigned Chunk = 4
) (
  input  logic [Chunk-1:0] a_i,
  input  logic [Chunk-1:0] b_i,
  input  logic             cin_i,
  output logic [Chunk-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [Chunk:0] full;

  // Carry into the MSB is recovered from the MSB sum bit, which also covers Chunk == 1.
  always_comb begin
    full   = {1'b0, a_i} + {1'b0, b_i} + {{Chunk{1'b0}}, cin_i};
    s_o    = full[Chunk-1:0];
    cout_o = full[Chunk];
    cmsb_o = a_i[Chunk-1] ^ b_i[Chunk-1] ^ full[Chunk-1];
  end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: WIDTH bits processed CHUNK bits per clock.
// Optional saturation on signed overflow is enabled by defining CHUNKED_ADDSUB_SAT_EN.
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             outc,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IW     = idx_width(NCHUNK);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_fin;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             outc_q, outc_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             cout, cmsb, last;

`ifdef CHUNKED_ADDSUB_SAT_EN
  logic [63:0] sat_full;
  assign sat_full = sat_pattern(WIDTH, a_q[WIDTH-1]);
`endif

  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];
  assign last    = (idx_q == IW'(NCHUNK - 1));

  addsub_chunk #(
    .Chunk(CHUNK)
  ) u_chunk (
    .a_i   (a_chunk),
    .b_i   (b_chunk),
    .cin_i (carry_q),
    .s_o   (s_chunk),
    .cout_o(cout),
    .cmsb_o(cmsb)
  );

  // Next-state and datapath updates for the idle/run/done sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    outc_d  = outc_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    sum_fin = sum_q;
    sum_fin[idx_q*CHUNK +: CHUNK] = s_chunk;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = input1;
          b_d     = sub ? ~input2 : input2;
          carry_d = sub;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d   = sum_fin;
        carry_d = cout;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          idx_d  = '0;
          outc_d = cout;
          // Only the MSB chunk's carries matter for signed overflow.
          ovf_d  = cmsb ^ cout;
`ifdef CHUNKED_ADDSUB_SAT_EN
          if (ovf_d) begin
            sum_d = sat_full[WIDTH-1:0];
          end
`endif
          zero_d  = (sum_d == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      outc_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      outc_q  <= outc_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign outc      = outc_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed self-checking bench for chunked_addsub (WIDTH=16, CHUNK=4).
module tb_chunked_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] input1 = '0;
  logic [15:0] input2 = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        outc, ovf, zero;

  int tests = 0;
  int fails = 0;

  chunked_addsub #(
    .WIDTH(16),
    .CHUNK(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .input1   (input1),
    .input2   (input2),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .outc     (outc),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operation in IDLE and let it be accepted on the next edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    in_valid = 1'b1;
    input1   = a;
    input2   = b;
    sub      = s;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    input1   = 16'hDEAD;
    input2   = 16'hBEEF;
    sub      = 1'b1;
  endtask

  // Count edges from acceptance to out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] esum, input logic ec,
                        input logic ev, input logic ez);
    int lat;
    start_op(a, b, s);
    wait_done(lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_outc"}, outc, ec);
    check({tag, "_ovf"}, ovf, ev);
    check({tag, "_zero"}, zero, ez);
    release_result();
    check({tag, "_back_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    int seen;
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_flags", {sum, outc, ovf, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add_basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    run_op("sub_zero", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef CHUNKED_ADDSUB_SAT_EN
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
    run_op("sub_borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: result held, new op not accepted while in DONE.
    start_op(16'h1234, 16'h1111, 1'b0);
    wait_done(lat);
    check("bp_latency", lat, 4);
    in_valid = 1'b1;
    input1   = 16'h0001;
    input2   = 16'h0002;
    sub      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold", {out_valid, in_ready, sum, outc, ovf, zero}, {2'b10, 16'h2345, 3'b000});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 0);
    wait_done(lat);
    check("bp_pending_latency", lat, 4);
    check("bp_pending_sum", sum, 16'h0003);
    release_result();

    // Reset after two RUN chunks aborts the operation.
    start_op(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", {out_valid, sum, outc, ovf, zero}, 0);
    check("abort_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    run_op("after_reset", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
